// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the MEM-stage RAM arbiter: FSM state encodings,
// default geometry and requester port indices.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2
  } arb_state_e;

  localparam int unsigned DefaultDataW = 32;
  localparam int unsigned DefaultRamAw = 10;

  localparam int unsigned Port0 = 0;
  localparam int unsigned Port1 = 1;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin grant logic. The pointer names the port that wins a tie and
// moves to the other port whenever a grant is taken (advance).
module mem_arbiter_rr_arb2
  import mem_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  logic ptr_q, ptr_d;

  always_comb begin
    gnt = 2'b00;
    unique case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = ptr_q ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

  // After serving port 0 the tie goes to port 1, and vice versa.
  always_comb begin
    ptr_d = ptr_q;
    if (advance && (gnt != 2'b00)) begin
      ptr_d = gnt[Port0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing the MEM-stage data RAM between the pipeline (port 0) and the
// debug/loader port (port 1). Define MEM_ARB_ALIGN_CHECK_EN to add err0/err1 alignment checks.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W = DefaultDataW,
  parameter int unsigned RAM_AW = DefaultRamAw,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [31:0]       addr0,
  input  logic [31:0]       addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
`ifdef MEM_ARB_ALIGN_CHECK_EN
  output logic              err0,
  output logic              err1,
`endif
  output logic              ram_we,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  arb_state_e        state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [RAM_AW-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              port_q, port_d;
  logic              misaligned;
  logic [1:0]        gnt;
  logic              grant;
  logic              issue;
  logic              rd_done;

  assign grant = (state_q == StIdle) && (gnt != 2'b00);

  mem_arbiter_rr_arb2 u_rr (
    .clk     (clk),
    .reset   (reset),
    .req     ({req1, req0}),
    .advance (grant),
    .gnt     (gnt)
  );

`ifdef MEM_ARB_ALIGN_CHECK_EN
  logic mis_q, mis_d;
  assign misaligned = mis_q;
  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr0[31:RAM_AW+2], addr1[31:RAM_AW+2]};
`else
  assign misaligned = 1'b0;
  // Upper bits wrap and byte-lane bits are don't-care in this build.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr0[31:RAM_AW+2], addr1[31:RAM_AW+2], addr0[1:0], addr1[1:0]};
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    port_d  = port_q;
`ifdef MEM_ARB_ALIGN_CHECK_EN
    mis_d   = mis_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (grant) begin
          port_d  = gnt[Port1];
          we_d    = gnt[Port1] ? we1 : we0;
          addr_d  = gnt[Port1] ? addr1[RAM_AW+1:2] : addr0[RAM_AW+1:2];
          wdata_d = gnt[Port1] ? wdata1 : wdata0;
`ifdef MEM_ARB_ALIGN_CHECK_EN
          mis_d   = gnt[Port1] ? (addr1[1:0] != 2'b00) : (addr0[1:0] != 2'b00);
`endif
          state_d = StIssue;
        end
      end
      StIssue: begin
        if (we_q || misaligned) begin
          state_d = StIdle;
        end else begin
          state_d = StWait;
          cnt_d   = 2'(RD_LAT);
        end
      end
      StWait: begin
        if (cnt_q == 2'd1) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= 2'd0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      port_q  <= 1'b0;
`ifdef MEM_ARB_ALIGN_CHECK_EN
      mis_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      port_q  <= port_d;
`ifdef MEM_ARB_ALIGN_CHECK_EN
      mis_q   <= mis_d;
`endif
    end
  end

  assign issue = (state_q == StIssue);
  // A reset arriving in the final wait cycle suppresses the read completion.
  assign rd_done = (state_q == StWait) && (cnt_q == 2'd1) && !reset;

  assign ack0     = issue && !port_q;
  assign ack1     = issue && port_q;
  assign rvalid0  = rd_done && !port_q;
  assign rvalid1  = rd_done && port_q;
  assign rdata    = rd_done ? ram_dout : '0;
  assign busy     = (state_q != StIdle);
  assign ram_we   = issue && we_q && !misaligned;
  assign ram_addr = addr_q;
  assign ram_din  = wdata_q;

`ifdef MEM_ARB_ALIGN_CHECK_EN
  assign err0 = issue && misaligned && !port_q;
  assign err1 = issue && misaligned && port_q;
`endif

endmodule
